// File: rtl/vga_timing_pkg.sv
// Purpose : shared 640x480@60 timing constants, coordinate type and the
//           control-bit bundle carried down the output delay line.
// Ports   : none (package).
package vga_timing_pkg;

  // Default 640x480@60 raster (25.175 MHz pixel clock).
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;  // 800
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;  // 525

  // Sync active level: 0 = active-low pulses.
  localparam logic DEF_SYNC_POL = 1'b0;

  // Counters and coordinates are 10-bit unsigned, so each axis total must
  // not exceed 1024.
  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // Control bits that travel alongside the colour pipeline.
  typedef struct packed {
    logic hs;   // horizontal sync pin level
    logic vs;   // vertical sync pin level
    logic act;  // visible pixel
  } vid_ctl_t;

  // Idle (blanked, sync deasserted) value for a given sync polarity.
  function automatic vid_ctl_t ctl_idle(input logic pol);
    vid_ctl_t c;
    c.hs  = ~pol;
    c.vs  = ~pol;
    c.act = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Purpose : bundles the pattern-generator handshake (coordinates out, colour
//           back) and the DAC/connector pins of the VGA timing generator.
// Ports   : master = timing generator side, slave = pattern generator / sink.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  // Colour returned by the pattern generator.
  logic   iRed;
  logic   iGreen;
  logic   iBlue;

  // Coordinates to the pattern generator.
  coord_t oVGA_X;
  coord_t oVGA_Y;

  // Connector / DAC pins.
  logic   oVGA_R;
  logic   oVGA_G;
  logic   oVGA_B;
  logic   oVGA_HS;
  logic   oVGA_VS;
  logic   oVGA_BLANK_N;
  logic   oFrame_Start;

  modport master (
    input  iRed, iGreen, iBlue,
    output oVGA_X, oVGA_Y,
    output oVGA_R, oVGA_G, oVGA_B,
    output oVGA_HS, oVGA_VS, oVGA_BLANK_N, oFrame_Start
  );

  modport slave (
    output iRed, iGreen, iBlue,
    input  oVGA_X, oVGA_Y,
    input  oVGA_R, oVGA_G, oVGA_B,
    input  oVGA_HS, oVGA_VS, oVGA_BLANK_N, oFrame_Start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// Purpose : one raster axis: counts 0..TOTAL-1 when enabled, decodes the
//           active region and the sync pulse, flags the wrap clock.
// Latency : count is registered; active/sync/wrap are decoded from it (0 clk).
// Backpres: none, free-running whenever en_i is high.
// Ports   : clk_i, rst_i (async, active-high), en_i -> count_o, active_o,
//           sync_o (pin level, SYNC_POL when asserted), wrap_o.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   ACTIVE   = DEF_H_ACTIVE,
  parameter int   FP       = DEF_H_FP,
  parameter int   SYNC     = DEF_H_SYNC,
  parameter int   BP       = DEF_H_BP,
  parameter logic SYNC_POL = DEF_SYNC_POL
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   en_i,
  output coord_t count_o,
  output logic   active_o,
  output logic   sync_o,
  output logic   wrap_o
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  // Decode boundaries are held one bit wider than the counter so that a
  // boundary equal to 1024 (a full 10-bit axis) still compares correctly.
  localparam logic [COORD_W:0] LAST_C     = (COORD_W+1)'(TOTAL - 1);
  localparam logic [COORD_W:0] ACT_END_C  = (COORD_W+1)'(ACTIVE);
  localparam logic [COORD_W:0] SYNC_BEG_C = (COORD_W+1)'(ACTIVE + FP);
  localparam logic [COORD_W:0] SYNC_END_C = (COORD_W+1)'(ACTIVE + FP + SYNC);

  coord_t           cnt_q;
  coord_t           cnt_d;
  logic [COORD_W:0] cnt_x;
  logic             at_last;
  logic             in_sync;

  assign cnt_x   = {1'b0, cnt_q};
  assign at_last = (cnt_x == LAST_C);
  assign in_sync = (cnt_x >= SYNC_BEG_C) && (cnt_x < SYNC_END_C);

  always_comb begin
    cnt_d  = cnt_q;
    wrap_o = 1'b0;
    if (en_i) begin
      if (at_last) begin
        cnt_d  = '0;
        wrap_o = 1'b1;
      end else begin
        cnt_d  = cnt_q + coord_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o  = cnt_q;
  assign active_o = (cnt_x < ACT_END_C);
  assign sync_o   = in_sync ? SYNC_POL : ~SYNC_POL;

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose : 640x480@60 VGA raster timing; drives X/Y to the pattern generator,
//           re-aligns HS/VS/BLANK_N with the returned colour, drives the pins.
// Latency : X/Y straight from the counters; colour and sync pins PIPE_DLY+1 clk
//           after the coordinate. Backpres: none, the raster is free-running.
// Ports   : iVGA_CLK, reset (async, active-high), vga (master modport:
//           iRed/iGreen/iBlue in; oVGA_X/Y, oVGA_R/G/B, HS, VS, BLANK_N,
//           oFrame_Start out).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = DEF_SYNC_POL,
  parameter int   PIPE_DLY = 1
) (
  input  logic                iVGA_CLK,
  input  logic                reset,
  vga_timing_gen_if.master    vga
);

  localparam vid_ctl_t IDLE = ctl_idle(SYNC_POL);

  // ---------------------------------------------------------------------
  // Run gate: the first clock after reset release holds the counters at
  // (0,0) so that the (0,0) pixel is presented for a full clock together
  // with oFrame_Start, and the first frame after release is full-length.
  // ---------------------------------------------------------------------
  logic run_q;
  logic run_d;

  assign run_d = 1'b1;

  // ---------------------------------------------------------------------
  // Axis counters
  // ---------------------------------------------------------------------
  coord_t h_cnt;
  coord_t v_cnt;
  logic   h_act;
  logic   v_act;
  logic   h_sync;
  logic   v_sync;
  logic   h_wrap;
  logic   v_wrap;

  vga_axis_counter #(
    .ACTIVE   (H_ACTIVE),
    .FP       (H_FP),
    .SYNC     (H_SYNC),
    .BP       (H_BP),
    .SYNC_POL (SYNC_POL)
  ) u_h_cnt (
    .clk_i    (iVGA_CLK),
    .rst_i    (reset),
    .en_i     (run_q),
    .count_o  (h_cnt),
    .active_o (h_act),
    .sync_o   (h_sync),
    .wrap_o   (h_wrap)
  );

  // Vertical axis advances only on the clock where the line wraps, so its
  // wrap flag marks the last pixel of the frame.
  vga_axis_counter #(
    .ACTIVE   (V_ACTIVE),
    .FP       (V_FP),
    .SYNC     (V_SYNC),
    .BP       (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_v_cnt (
    .clk_i    (iVGA_CLK),
    .rst_i    (reset),
    .en_i     (h_wrap),
    .count_o  (v_cnt),
    .active_o (v_act),
    .sync_o   (v_sync),
    .wrap_o   (v_wrap)
  );

  // Each coordinate is clamped on its own axis so the pattern generator never
  // sees an out-of-range X or Y.
  assign vga.oVGA_X = h_act ? h_cnt : '0;
  assign vga.oVGA_Y = v_act ? v_cnt : '0;

  // ---------------------------------------------------------------------
  // Control delay line: stage 0 is the live decode, stages 1..PIPE_DLY+1 are
  // registers. The last register stage drives the pins.
  // ---------------------------------------------------------------------
  vid_ctl_t                 cur_ctl;
  vid_ctl_t [PIPE_DLY:0]    dly_q;
  vid_ctl_t [PIPE_DLY:0]    dly_d;

  always_comb begin
    cur_ctl = IDLE;
    if (run_q) begin
      cur_ctl.hs  = h_sync;
      cur_ctl.vs  = v_sync;
      cur_ctl.act = h_act & v_act;
    end
  end

  always_comb begin
    dly_d    = dly_q;
    dly_d[0] = cur_ctl;
    for (int i = 1; i <= PIPE_DLY; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  // ---------------------------------------------------------------------
  // Colour register. dly_d[PIPE_DLY] is the active bit of the coordinate
  // whose colour the pattern generator is returning right now, and it is
  // loaded into the last delay stage on the same edge, so RGB, BLANK_N and
  // sync all change together and blanked colour is dropped.
  // ---------------------------------------------------------------------
  logic [2:0] rgb_q;
  logic [2:0] rgb_d;

  always_comb begin
    rgb_d = 3'b000;
    if (dly_d[PIPE_DLY].act) begin
      rgb_d = {vga.iRed, vga.iGreen, vga.iBlue};
    end
  end

  // ---------------------------------------------------------------------
  // Frame start: registered so it is high exactly while the counters sit at
  // (0,0) -- on the hold clock after reset and after every frame wrap.
  // ---------------------------------------------------------------------
  logic fs_q;
  logic fs_d;

  assign fs_d = ~run_q | v_wrap;

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      run_q <= 1'b0;
      fs_q  <= 1'b0;
      rgb_q <= 3'b000;
      for (int i = 0; i <= PIPE_DLY; i++) begin
        dly_q[i] <= IDLE;
      end
    end else begin
      run_q <= run_d;
      fs_q  <= fs_d;
      rgb_q <= rgb_d;
      dly_q <= dly_d;
    end
  end

  // ---------------------------------------------------------------------
  // Pins
  // ---------------------------------------------------------------------
  assign vga.oVGA_R       = rgb_q[2];
  assign vga.oVGA_G       = rgb_q[1];
  assign vga.oVGA_B       = rgb_q[0];
  assign vga.oVGA_HS      = dly_q[PIPE_DLY].hs;
  assign vga.oVGA_VS      = dly_q[PIPE_DLY].vs;
  assign vga.oVGA_BLANK_N = dly_q[PIPE_DLY].act;
  assign vga.oFrame_Start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  // Reduced raster for frame-level checks (25 x 13 = 325 clocks per frame).
  localparam int SH_A = 16, SH_FP = 2, SH_S = 4, SH_BP = 3, SH_T = 25;
  localparam int SV_A = 6,  SV_FP = 2, SV_S = 2, SV_BP = 3, SV_T = 13;
  localparam int LAT  = 2;  // PIPE_DLY + 1

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_timing_gen_if vif();  // default 640x480 instance
  vga_timing_gen_if sif();  // reduced-raster instance

  vga_timing_gen dut (
    .iVGA_CLK (clk),
    .reset    (reset),
    .vga      (vif)
  );

  vga_timing_gen #(
    .H_ACTIVE (SH_A), .H_FP (SH_FP), .H_SYNC (SH_S), .H_BP (SH_BP),
    .V_ACTIVE (SV_A), .V_FP (SV_FP), .V_SYNC (SV_S), .V_BP (SV_BP),
    .SYNC_POL (1'b0), .PIPE_DLY (1)
  ) dut_s (
    .iVGA_CLK (clk),
    .reset    (reset),
    .vga      (sif)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  typedef struct packed {
    logic hs;
    logic vs;
    logic bl;
    logic r;
    logic g;
    logic b;
  } pins_t;

  pins_t sq[$];           // scoreboard for the reduced instance
  int    mh = 0, mv = 0;  // reference raster position
  int    cyc = -1;        // clocks since the frame-start clock
  bit    run = 1'b0;
  bit    fresh = 1'b0;
  int    phase = 1;
  logic  sp_r = 1'b0, sp_g = 1'b0, sp_b = 1'b0;
  logic  dp_r = 1'b0;
  int    d_r_hi, d_hs_lo, d_xmax;
  int    s_hs_run, s_vs_run, last_fs;

  // Pattern-generator models: colour chosen from the coordinate seen on one
  // clock, presented after the next edge (one clock of latency).
  initial begin
    sif.iRed = 1'b0; sif.iGreen = 1'b0; sif.iBlue = 1'b0;
    vif.iRed = 1'b0; vif.iGreen = 1'b1; vif.iBlue = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      sif.iRed   = sp_r;
      sif.iGreen = sp_g;
      sif.iBlue  = sp_b;
      vif.iRed   = dp_r;
    end
  end

  // Per-cycle reference model and scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (run) begin : cycle_chk
        pins_t e;
        pins_t got;
        logic  cr, cg, cb, act;
        int    ex_x, ex_y, md;
        if (fresh) begin
          mh = 0; mv = 0; cyc = 0; fresh = 1'b0;
          s_hs_run = 0; s_vs_run = 0; last_fs = -1;
          d_r_hi = 0; d_hs_lo = 0; d_xmax = 0;
        end else begin
          cyc++;
          mh++;
          if (mh == SH_T) begin
            mh = 0;
            mv++;
            if (mv == SV_T) mv = 0;
          end
        end
        ex_x = (mh < SH_A) ? mh : 0;
        ex_y = (mv < SV_A) ? mv : 0;
        chk("s_x",  32'(sif.oVGA_X), ex_x);
        chk("s_y",  32'(sif.oVGA_Y), ex_y);
        chk("s_fs", 32'(sif.oFrame_Start), 32'((mh == 0) && (mv == 0)));

        md = (phase == 1) ? ((cyc < 325) ? 0 : ((cyc < 650) ? 1 : 2)) : 2;
        case (md)
          0: begin cr = (ex_x == 5); cg = ex_x[0]; cb = 1'($urandom_range(0, 1)); end
          1: begin cr = 1'b1; cg = 1'b1; cb = 1'b1; end
          default: begin
            cr = 1'($urandom_range(0, 1));
            cg = 1'($urandom_range(0, 1));
            cb = 1'($urandom_range(0, 1));
          end
        endcase
        act  = (mh < SH_A) && (mv < SV_A);
        e.hs = !((mh >= SH_A + SH_FP) && (mh < SH_A + SH_FP + SH_S));
        e.vs = !((mv >= SV_A + SV_FP) && (mv < SV_A + SV_FP + SV_S));
        e.bl = act;
        e.r  = act & cr;
        e.g  = act & cg;
        e.b  = act & cb;
        sq.push_back(e);
        sp_r = cr; sp_g = cg; sp_b = cb;
        if (sq.size() > LAT) begin
          got = {sif.oVGA_HS, sif.oVGA_VS, sif.oVGA_BLANK_N, sif.oVGA_R, sif.oVGA_G, sif.oVGA_B};
          chk("s_pins", 32'(got), 32'(sq.pop_front()));
        end

        // Sync pulse widths and frame spacing on the reduced instance.
        if (!sif.oVGA_HS) s_hs_run++;
        else if (s_hs_run > 0) begin chk("s_hs_width", s_hs_run, SH_S); s_hs_run = 0; end
        if (!sif.oVGA_VS) s_vs_run++;
        else if (s_vs_run > 0) begin chk("s_vs_width", s_vs_run, SV_S * SH_T); s_vs_run = 0; end
        if (sif.oFrame_Start) begin
          if (last_fs >= 0) chk("s_frame_period", cyc - last_fs, SH_T * SV_T);
          last_fs = cyc;
        end

        // Default instance: constant green must track BLANK_N exactly.
        chk("d_g_eq_blank", 32'(vif.oVGA_G), 32'(vif.oVGA_BLANK_N));
        if (phase == 1 && cyc < 2400) begin
          if (vif.oVGA_R) d_r_hi++;
          if (!vif.oVGA_HS) d_hs_lo++;
          if (int'(vif.oVGA_X) > d_xmax) d_xmax = int'(vif.oVGA_X);
        end
        dp_r = (vif.oVGA_X == 10'd240);
      end
    end
  end

  task automatic start_run();
    pins_t idle;
    idle  = '{hs: 1'b1, vs: 1'b1, bl: 1'b0, r: 1'b0, g: 1'b0, b: 1'b0};
    reset = 1'b0;
    cyc   = -1;
    sq.delete();
    for (int i = 0; i < LAT; i++) sq.push_back(idle);
    fresh = 1'b1;
    run   = 1'b1;
  endtask

  task automatic wait_cyc(input int n);
    int g;
    g = 0;
    while (cyc != n && g < 5000) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (cyc != n) chk("wait_cyc_timeout", cyc, n);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_reset_d"},
        32'({vif.oVGA_X, vif.oVGA_Y, vif.oVGA_R, vif.oVGA_G, vif.oVGA_B,
             vif.oVGA_HS, vif.oVGA_VS, vif.oVGA_BLANK_N, vif.oFrame_Start}),
        32'({20'd0, 3'b000, 2'b11, 2'b00}));
    chk({tag, "_reset_s"},
        32'({sif.oVGA_X, sif.oVGA_Y, sif.oVGA_R, sif.oVGA_G, sif.oVGA_B,
             sif.oVGA_HS, sif.oVGA_VS, sif.oVGA_BLANK_N, sif.oFrame_Start}),
        32'({20'd0, 3'b000, 2'b11, 2'b00}));
  endtask

  // Default-raster vectors, offsets counted from the frame-start clock.
  // Pins reflect the coordinate two clocks earlier; red is set for X==240.
  typedef struct {
    int off; int x; int y; int fs; int hs; int bl; int r;
  } vec_t;
  vec_t tbl[16];

  task automatic run_table(input string tag);
    for (int i = 0; i < 16; i++) begin
      wait_cyc(tbl[i].off);
      chk($sformatf("%s_x[%0d]",  tag, i), 32'(vif.oVGA_X),       tbl[i].x);
      chk($sformatf("%s_y[%0d]",  tag, i), 32'(vif.oVGA_Y),       tbl[i].y);
      chk($sformatf("%s_fs[%0d]", tag, i), 32'(vif.oFrame_Start), tbl[i].fs);
      chk($sformatf("%s_hs[%0d]", tag, i), 32'(vif.oVGA_HS),      tbl[i].hs);
      chk($sformatf("%s_vs[%0d]", tag, i), 32'(vif.oVGA_VS),      1);
      chk($sformatf("%s_bl[%0d]", tag, i), 32'(vif.oVGA_BLANK_N), tbl[i].bl);
      chk($sformatf("%s_r[%0d]",  tag, i), 32'(vif.oVGA_R),       tbl[i].r);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int g;
    //          off   x    y  fs hs bl r
    tbl[0]  = '{0,    0,   0, 1, 1, 0, 0};
    tbl[1]  = '{1,    1,   0, 0, 1, 0, 0};
    tbl[2]  = '{2,    2,   0, 0, 1, 1, 0};
    tbl[3]  = '{241,  241, 0, 0, 1, 1, 0};
    tbl[4]  = '{242,  242, 0, 0, 1, 1, 1};
    tbl[5]  = '{243,  243, 0, 0, 1, 1, 0};
    tbl[6]  = '{639,  639, 0, 0, 1, 1, 0};
    tbl[7]  = '{640,  0,   0, 0, 1, 1, 0};
    tbl[8]  = '{642,  0,   0, 0, 1, 0, 0};
    tbl[9]  = '{657,  0,   0, 0, 1, 0, 0};
    tbl[10] = '{658,  0,   0, 0, 0, 0, 0};
    tbl[11] = '{753,  0,   0, 0, 0, 0, 0};
    tbl[12] = '{754,  0,   0, 0, 1, 0, 0};
    tbl[13] = '{800,  0,   1, 0, 1, 0, 0};
    tbl[14] = '{802,  2,   1, 0, 1, 1, 0};
    tbl[15] = '{1042, 242, 1, 0, 1, 1, 1};

    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_reset("init");
    #1;
    start_run();

    // Phase 1: default raster vectors, then three full lines of statistics.
    run_table("p1");
    wait_cyc(2400);
    chk("d_red_pixels_3_lines", d_r_hi, 3);
    chk("d_hs_low_3_lines", d_hs_lo, 3 * 96);
    chk("d_x_max", d_xmax, 639);

    // Reset in the middle of the reduced instance's vertical sync.
    g = 0;
    while (!(mv == SV_A + SV_FP && mh == 10) && g < 1000) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk("reach_vsync", 32'(mv == SV_A + SV_FP && mh == 10), 1);
    chk("s_vs_low_before_reset", 32'(sif.oVGA_VS), 0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    run   = 1'b0;
    #1;
    check_reset("mid");
    repeat (2) @(negedge clk);
    #2;
    phase = 2;
    start_run();

    // Phase 2: restart from (0,0), then the frame wrap on the reduced raster.
    run_table("p2");
    g = 0;
    while (!(mh == SH_T - 1 && mv == SV_T - 1) && g < 1000) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk("reach_wrap", 32'(mh == SH_T - 1 && mv == SV_T - 1), 1);
    @(negedge clk);
    #1;
    chk("s_wrap_xyfs", 32'({sif.oVGA_X, sif.oVGA_Y, sif.oFrame_Start}),
        32'({10'd0, 10'd0, 1'b1}));
    wait_cyc(1700);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the 25.175 MHz pixel clock. It drives pixel coordinates to the pattern generator (`VGA_Pattern`) and accepts that block's registered 1-bit RGB back. It re-aligns HS/VS/blank with the returned colour and drives the DAC/connector pins. It is the counterpart of the pattern generator: it produces `iVGA_X`/`iVGA_Y` and consumes `oRed`/`oGreen`/`oBlue`.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)
- PIPE_DLY, 1, colour-source latency in clocks (coordinate to colour)

Ports:
- iVGA_CLK  in  1  pixel clock
- reset  in  1  reset, asynchronous, active-high
- iRed, iGreen, iBlue  in  1 each  colour from the pattern generator
- oVGA_X  out  10  pixel column, 0..H_ACTIVE-1, 0 outside the active area
- oVGA_Y  out  10  pixel row, 0..V_ACTIVE-1, 0 outside the active area
- oVGA_R, oVGA_G, oVGA_B  out  1 each  colour to the connector, forced 0 when blanked
- oVGA_HS, oVGA_VS  out  1 each  sync pulses
- oVGA_BLANK_N  out  1  high during visible pixels
- oFrame_Start  out  1  one-clock pulse at coordinate (0,0)

## Operation
- **Horizontal counter h_cnt**
  - Range 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - Increments every clock and wraps to 0.
- **Vertical counter v_cnt**
  - Range 0..V_TOTAL-1, where V_TOTAL = 525.
  - Increments only on the clock where h_cnt wraps.
  - Wraps to 0 when h_cnt and v_cnt are both at their maxima in the same clock.
- **Active region**
  - h_act = h_cnt < H_ACTIVE; v_act = v_cnt < V_ACTIVE; active = h_act & v_act.
- **Sync pulses**
  - HS is asserted (level SYNC_POL) for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - VS is asserted for v_cnt 490..491.
  - Both are deasserted (level ~SYNC_POL) otherwise.
- **Coordinates**
  - oVGA_X/oVGA_Y are driven directly from the counter registers.
  - Each is clamped to 0 when its own axis is inactive, so the pattern generator never sees X >= 640 or Y >= 480.
- **Output pipeline**
  - {hs, vs, active} pass through a delay line of depth PIPE_DLY+1.
  - RGB is registered once, gated by the active bit at delay stage PIPE_DLY.
  - oVGA_R/G/B, oVGA_HS, oVGA_VS and oVGA_BLANK_N therefore change on the same edge.
- **Frame start**
  - oFrame_Start is registered, high for exactly one clock while h_cnt==0 and v_cnt==0.
  - It is coincident with oVGA_X==0 and oVGA_Y==0, not delayed.
- **Width rules**
  - H_TOTAL and V_TOTAL must each be <= 1024; the counters are 10-bit unsigned.
  - No signed arithmetic; all comparisons are against elaborated constants.

## Timing
- **Reset values** (asynchronous, immediate on assertion):
  - h_cnt = v_cnt = 0; oVGA_X = oVGA_Y = 0.
  - oVGA_R/G/B = 0; oVGA_BLANK_N = 0; oFrame_Start = 0.
  - oVGA_HS = oVGA_VS = ~SYNC_POL; all delay-line stages cleared to inactive/deasserted.
- **First clock after reset release**
  - Counters start at (0,0) and oFrame_Start pulses.
- **Latency**
  - Coordinate (x,y) presented at edge t gets its colour on oVGA_R/G/B at edge t+PIPE_DLY+1.
  - The matching BLANK_N/HS/VS appear on that same edge.
- **Line period**
  - 800 clocks; visible 640, HS low for 96.
- **Frame period**
  - 420000 clocks between oFrame_Start pulses.
- **Reset mid-frame**
  - The raster aborts immediately, with no partial sync pulse held.
  - The first frame after release is full-length.
- **Unaligned colour**
  - Colour present while blanked is discarded.
  - Colour changes are never visible before BLANK_N rises.

## Structure
- Package vga_timing_pkg:
  - 640x480 timing constants (H_*/V_* defaults, H_TOTAL, V_TOTAL).
  - The sync-polarity constant.
  - A 10-bit coord_t typedef.
- Sub-module vga_axis_counter, instantiated twice (horizontal and vertical):
  - Parameters ACTIVE/FP/SYNC/BP/SYNC_POL.
  - Inputs: clock, reset, enable.
  - Outputs: count, active, sync, wrap.
  - The vertical instance is enabled by the horizontal wrap.
- Top level contains the delay line, RGB gating register and frame-start pulse.

## Test plan
- **Reset:** assert reset mid-line -> all outputs at reset values within the same cycle. Release -> oFrame_Start high for 1 clock with oVGA_X=0, oVGA_Y=0.
- **Horizontal timing:** count clocks from line start.
  - oVGA_HS low exactly on counts 656..751 (96 clocks), delayed by PIPE_DLY+1.
  - Line period 800; oVGA_X runs 0..639, then holds 0 for 160 clocks.
- **Vertical timing:** oVGA_VS low for exactly 1600 clocks (lines 490..491). oVGA_Y runs 0..479; oFrame_Start spacing 420000 clocks.
- **Wrap:** at h_cnt=799, v_cnt=524 -> the next clock gives (0,0), v_cnt does not overshoot, and oFrame_Start pulses.
- **Alignment:**
  - Drive a colour model with PIPE_DLY=1: iRed=1 only when X==240 on the prior clock.
  - oVGA_R must be high exactly one pixel per visible line, in the same cycle as oVGA_BLANK_N high.
  - Constant iRed=1 -> oVGA_R equals oVGA_BLANK_N on every cycle.
- **Blank gating:** hold iRed=iGreen=iBlue=1 during blanking -> oVGA_R/G/B remain 0 for all cycles with oVGA_BLANK_N=0.
